// File: rtl/right_shift_seq.sv
// Sequential right shifter: shifts one bit per clock, logical or arithmetic.
// A request is latched in IDLE, shifted in SHIFT and reported in DONE
// with a one-cycle done pulse. The result register only updates on DONE entry.
module right_shift_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5   // WIDTH must equal 2**SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0] CNT_ZERO = '0;

  state_t           state_reg;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] shift_next;
  logic [SHW-1:0]   count_reg;
  logic             mode_reg;
  logic [WIDTH-1:0] res_reg;
  logic             busy_reg;
  logic             done_reg;

  // One-bit right shift of the working register; each bit takes its upper neighbour
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign shift_next[gi] = work_reg[gi + 1];
    end
  endgenerate

  // Top bit is refilled with the sign (arithmetic mode) or zero (logical mode)
  assign shift_next[WIDTH-1] = mode_reg & work_reg[WIDTH-1];

  // Control FSM plus datapath registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      count_reg <= '0;
      mode_reg  <= 1'b0;
      res_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            work_reg  <= in;
            count_reg <= shamt;
            mode_reg  <= arith;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (count_reg != CNT_ZERO) begin
            work_reg  <= shift_next;
            count_reg <= count_reg - CNT_ONE;
          end else begin
            // Counter exhausted: publish the result and raise done next cycle
            res_reg   <= work_reg;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign res  = res_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_right_shift_seq.sv
// Self-checking bench for right_shift_seq: directed vector table, hand-written
// multi-cycle corner sequences and random operations against a shift model.
module tb_right_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in;
  logic [4:0]  shamt;
  logic        arith;
  logic [31:0] res;
  logic        busy;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  right_shift_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in),
    .shamt (shamt),
    .arith (arith),
    .res   (res),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vin;
    int          vsh;
    bit          var_a;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  // Reference: plain shift operators on the whole word
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int s, input bit ar);
    if (ar) return 32'($signed(a) >>> s);
    else    return a >> s;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the operands (don't-care afterwards)
  task automatic start_op(input logic [31:0] a, input int s, input bit ar);
    start = 1'b1;
    in    = a;
    shamt = 5'(s);
    arith = ar;
    step();
    start = 1'b0;
    in    = $urandom;
    shamt = 5'($urandom_range(0, 31));
    arith = 1'($urandom_range(0, 1));
  endtask

  // Called in cycle T+n0; waits for done, checking busy and res stability along the way
  task automatic wait_done(input string name, input int n0, input logic [31:0] exp_res,
                           input int exp_lat);
    int n;
    logic [31:0] res_before;
    bit busy_ok, hold_ok;
    n = n0;
    res_before = res;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (1) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) break;
      if (res !== res_before) hold_ok = 1'b0;
      if (n >= 100) begin
        total_cnt++;
        $display("FAIL %s timeout: no done after %0d cycles, required at %0d", name, n, exp_lat);
        return;
      end
      step();
      n++;
    end
    check({name, " busy"}, 32'(busy_ok), 32'd1);
    check({name, " res_hold"}, 32'(hold_ok), 32'd1);
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " res"}, res, exp_res);
    step();
    check({name, " done_pulse"}, {31'd0, done}, 32'd0);
    check({name, " busy_end"}, {31'd0, busy}, 32'd0);
    check({name, " res_kept"}, res, exp_res);
  endtask

  vec_t vecs[6];

  initial begin
    logic [31:0] a, e;
    int s, gap;
    bit ar, extra_done;

    vecs[0] = '{32'h80000000, 4,  1'b0, 32'h08000000, 6};
    vecs[1] = '{32'h80000000, 4,  1'b1, 32'hF8000000, 6};
    vecs[2] = '{32'hDEADBEEF, 0,  1'b1, 32'hDEADBEEF, 2};
    vecs[3] = '{32'h80000001, 31, 1'b1, 32'hFFFFFFFF, 33};
    vecs[4] = '{32'h80000001, 31, 1'b0, 32'h00000001, 33};
    vecs[5] = '{32'h7FFFFFFF, 31, 1'b1, 32'h00000000, 33};

    rst = 1'b1; start = 1'b0; in = '0; shamt = '0; arith = 1'b0;
    step(); step();
    check("reset res", res, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);

    // Reset takes priority over a simultaneous start
    start = 1'b1; in = 32'h12345678; shamt = 5'd3;
    step();
    check("rst_prio busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    step(); step();
    check("rst_prio idle", {31'd0, busy}, 32'd0);

    // Directed vector table
    foreach (vecs[i]) begin
      start_op(vecs[i].vin, vecs[i].vsh, vecs[i].var_a);
      wait_done($sformatf("vec%0d", i), 1, vecs[i].exp_res, vecs[i].exp_lat);
    end

    // Start while busy is ignored, and no second done follows
    start_op(32'h000000F0, 4, 1'b0);
    step();                               // cycle T+2
    start = 1'b1; in = 32'hFFFFFFFF; shamt = 5'd1; arith = 1'b1;
    step();                               // cycle T+3
    start = 1'b0;
    wait_done("busy_start", 3, 32'h0000000F, 6);
    extra_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done === 1'b1) extra_done = 1'b1;
      step();
    end
    check("busy_start no_second_done", 32'(extra_done), 32'd0);

    // Reset mid-SHIFT aborts; start right after reset is accepted
    start_op(32'hCAFEF00D, 10, 1'b0);     // now cycle T+1
    step();                               // T+2
    rst = 1'b1;
    step();                               // T+3 with rst high
    step();                               // T+4, reset applied
    check("abort res", res, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    start_op(32'h00000100, 8, 1'b0);
    wait_done("after_rst", 1, 32'h00000001, 10);

    // Random operations against the reference model
    for (int r = 0; r < 40; r++) begin
      a  = $urandom;
      s  = $urandom_range(0, 31);
      ar = 1'($urandom_range(0, 1));
      if (r % 4 == 0) a[31] = 1'b1;
      e  = ref_shift(a, s, ar);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      start_op(a, s, ar);
      wait_done($sformatf("rand%0d a=%h s=%0d ar=%0d", r, a, s, ar), 1, e, s + 2);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
